// File: rtl/regfile_scoreboard.sv
// Parametrised ID-stage register file. Provides same-cycle write-to-read bypass,
// a per-register pending-write scoreboard, and a sequential clear after reset.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            RegWrite,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            pending1,
  output logic            pending2,
  output logic            init_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic          HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   clr_idx;
  logic [AW-1:0]   clr_idx_next;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;

  logic run;
  logic wr_legal;
  logic set_legal;

  // Register 0 is excluded from writes and pending-sets when hardwired
  assign run       = !rst && (state == RUN);
  assign wr_legal  = run && RegWrite && !(HAS_ZERO && (rd == '0));
  assign set_legal = run && issue_valid && !(HAS_ZERO && (issue_rd == '0));
  assign init_busy = rst || (state == CLEAR);

  // Clear-engine state register and index counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // Walk every index once, then hand over to normal operation
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_next = clr_idx + AW'(1);
        if (clr_idx == LAST_IDX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Register array: zeroed one entry per cycle during clear, WB writes in run
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (wr_legal) begin
        regs[rd] <= write_data;
      end
    end
  end

  // Scoreboard: set after clear so a new producer on the same index wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (run) begin
      if (wr_legal) begin
        pending[rd] <= 1'b0;
      end
      if (set_legal) begin
        pending[issue_rd] <= 1'b1;
      end
    end
  end

  // Read port 1 with bypass from the write port
  always_comb begin
    read_data1 = '0;
    if (run) begin
      if (wr_legal && (rs1 == rd)) begin
        read_data1 = write_data;
      end else if (HAS_ZERO && (rs1 == '0)) begin
        read_data1 = '0;
      end else begin
        read_data1 = regs[rs1];
      end
    end
  end

  // Read port 2 with bypass from the write port
  always_comb begin
    read_data2 = '0;
    if (run) begin
      if (wr_legal && (rs2 == rd)) begin
        read_data2 = write_data;
      end else if (HAS_ZERO && (rs2 == '0)) begin
        read_data2 = '0;
      end else begin
        read_data2 = regs[rs2];
      end
    end
  end

  // Hazard flags drop in the write-back cycle, matching the data bypass
  always_comb begin
    pending1 = run && pending[rs1] && !(wr_legal && (rd == rs1));
    pending2 = run && pending[rs2] && !(wr_legal && (rd == rs2));
  end

endmodule
